// File: rtl/dc_link_pkg.sv
// Shared definitions for the DC/launch command link: marker word, header
// encoding and the packer state encoding.
package dc_link_pkg;

  localparam logic [31:0] LAUNCH_MARKER   = 32'hFFFF_FFFF;
  localparam int          HDR_TAG_W       = 8;
  localparam int          DAC_CHANNEL_MAX = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_SEND_PAYLOAD,
    ST_SEND_MARK,
    ST_SEND_LAUNCH
  } packer_state_e;

  // One-cold channel select in [31:8]; a single zero bit keeps a header from
  // ever aliasing the launch marker.
  function automatic logic [31:0] encode_hdr(input logic [4:0] channel,
                                             input logic [HDR_TAG_W-1:0] tag = '0);
    logic [DAC_CHANNEL_MAX-1:0] sel;
    sel = '1;
    if (int'(channel) < DAC_CHANNEL_MAX) sel[channel] = 1'b0;
    return {sel, tag};
  endfunction

endpackage

// File: rtl/dc_frame_packer.sv
// Serializes DC frames (header + payload) and launch commands (marker + words)
// into the command FIFO, honouring FIFO back-pressure.
module dc_frame_packer
  import dc_link_pkg::*;
#(
  parameter int          DAC_CHANNEL  = 24,
  parameter int          FRAME_WORDS  = 62,
  parameter int          LAUNCH_WORDS = 4,
  parameter logic [7:0]  HDR_TAG      = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_valid,
  output logic        o_frame_ready,
  input  logic [4:0]  i_channel_sel,
  input  logic [31:0] i_dc_regs [FRAME_WORDS],
  input  logic        i_launch_valid,
  output logic        o_launch_ready,
  input  logic [31:0] i_launch_cmd [LAUNCH_WORDS],
  output logic [31:0] o_fifo_data,
  output logic        o_fifo_wr,
  input  logic        i_fifo_full,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_launch_done,
  output logic        o_err_chan
);

  localparam int CNT_W  = 6;
  localparam int FW_IDX = (FRAME_WORDS  > 1) ? $clog2(FRAME_WORDS)  : 1;
  localparam int LW_IDX = (LAUNCH_WORDS > 1) ? $clog2(LAUNCH_WORDS) : 1;

  packer_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         chan_q;
  logic [31:0]        frame_snap  [FRAME_WORDS];
  logic [31:0]        launch_snap [LAUNCH_WORDS];
  logic               load_frame, load_launch;
  logic               frame_done_d, launch_done_d, err_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_frame     = 1'b0;
    load_launch    = 1'b0;
    frame_done_d   = 1'b0;
    launch_done_d  = 1'b0;
    err_d          = 1'b0;
    o_fifo_data    = '0;
    o_fifo_wr      = (state_q != ST_IDLE) && !i_fifo_full;
    o_launch_ready = (state_q == ST_IDLE);
    o_frame_ready  = (state_q == ST_IDLE) && !i_launch_valid;
    o_busy         = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // Launch has priority; a concurrent frame simply waits for the next IDLE.
        if (i_launch_valid) begin
          load_launch = 1'b1;
          state_d     = ST_SEND_MARK;
        end else if (i_frame_valid) begin
          if (int'(i_channel_sel) < DAC_CHANNEL) begin
            load_frame = 1'b1;
            state_d    = ST_SEND_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEND_HDR: begin
        o_fifo_data = encode_hdr(chan_q, HDR_TAG);
        if (o_fifo_wr) begin
          cnt_d   = '0;
          state_d = ST_SEND_PAYLOAD;
        end
      end
      ST_SEND_PAYLOAD: begin
        o_fifo_data = frame_snap[cnt_q[FW_IDX-1:0]];
        if (o_fifo_wr) begin
          if (cnt_q == CNT_W'(FRAME_WORDS - 1)) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SEND_MARK: begin
        o_fifo_data = LAUNCH_MARKER;
        if (o_fifo_wr) begin
          cnt_d   = '0;
          state_d = ST_SEND_LAUNCH;
        end
      end
      ST_SEND_LAUNCH: begin
        o_fifo_data = launch_snap[cnt_q[LW_IDX-1:0]];
        if (o_fifo_wr) begin
          if (cnt_q == CNT_W'(LAUNCH_WORDS - 1)) begin
            cnt_d         = '0;
            launch_done_d = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      chan_q        <= '0;
      frame_snap    <= '{default: '0};
      launch_snap   <= '{default: '0};
      o_frame_done  <= 1'b0;
      o_launch_done <= 1'b0;
      o_err_chan    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      o_frame_done  <= frame_done_d;
      o_launch_done <= launch_done_d;
      o_err_chan    <= err_d;
      if (load_frame) begin
        frame_snap <= i_dc_regs;
        chan_q     <= i_channel_sel;
      end
      if (load_launch) launch_snap <= i_launch_cmd;
    end
  end

  a_no_wr_when_full : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_fifo_wr && i_fifo_full));

  a_hdr_one_cold : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == ST_SEND_HDR) |->
      ($countones(o_fifo_data[31:32-DAC_CHANNEL]) == DAC_CHANNEL - 1));

endmodule

// File: doc/dc_frame_packer.md
Name: dc_frame_packer

Overview:
- Transmit-side serializer for the DC/launch word stream into the command FIFO.
- Accepts either a DC frame (channel select plus FRAME_WORDS register words) or a launch command (LAUNCH_WORDS words).
- Emits the exact word sequence the FIFO-side DC dispatcher decodes: header, then payload; or marker 0xFFFF_FFFF, then launch words.
- Honours FIFO back-pressure and snapshots each request so the source is free once it is accepted.

Parameters:
- DAC_CHANNEL, 24, number of DAC channels; width of the one-cold header select field.
- FRAME_WORDS, 62, payload words per DC frame.
- LAUNCH_WORDS, 4, words per launch command.
- HDR_TAG, 8'h00, constant placed in header bits [7:0].

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_frame_valid  input  1  DC frame request.
- o_frame_ready  output  1  frame accepted when valid&&ready.
- i_channel_sel  input  5  target channel 0..DAC_CHANNEL-1.
- i_dc_regs  input  FRAME_WORDS x 32  payload; element 0 is sent first.
- i_launch_valid  input  1  launch request.
- o_launch_ready  output  1  launch accepted when valid&&ready.
- i_launch_cmd  input  LAUNCH_WORDS x 32  launch words; element 0 is sent first.
- o_fifo_data  output  32  FIFO write data.
- o_fifo_wr  output  1  FIFO write enable.
- i_fifo_full  input  1  FIFO full.
- o_busy  output  1  state != IDLE.
- o_frame_done  output  1  one-cycle pulse after the last payload word is written.
- o_launch_done  output  1  one-cycle pulse after the last launch word is written.
- o_err_chan  output  1  one-cycle pulse when a frame is dropped for an illegal channel.

Behaviour:
- Reset (i_rst_n=0 at posedge), from any state including mid-frame:
  - state=IDLE, counter=0, snapshots=0.
  - o_fifo_wr=0, all pulses 0.
  - A partially sent frame is abandoned; no completion pulse is issued.
- State machine:
  - States: IDLE, SEND_HDR, SEND_PAYLOAD, SEND_MARK, SEND_LAUNCH.
  - Word counter is 6 bits.
- IDLE behaviour:
  - o_launch_ready=1 and o_frame_ready=!i_launch_valid (combinational). Launch wins if both requests are present; the frame waits.
  - On launch accept: snapshot i_launch_cmd, go to SEND_MARK.
  - On frame accept with i_channel_sel<DAC_CHANNEL: snapshot i_dc_regs and the channel, go to SEND_HDR.
  - On frame accept with i_channel_sel>=DAC_CHANNEL: pulse o_err_chan next cycle, stay IDLE, write nothing.
- Write rule: o_fifo_wr = (state != IDLE) && !i_fifo_full (combinational). A word advances only on a cycle with o_fifo_wr=1. While the FIFO is full, o_fifo_data holds its value.
- SEND_HDR:
  - o_fifo_data = {hdr24, HDR_TAG}.
  - hdr24 is all ones except bit[channel]=0; bits at or above DAC_CHANNEL are 1.
  - On write: counter=0, go to SEND_PAYLOAD.
- SEND_PAYLOAD:
  - o_fifo_data = snapshot[counter].
  - On write with counter==FRAME_WORDS-1: go to IDLE, o_frame_done=1 next cycle.
  - Otherwise counter+1.
- SEND_MARK:
  - o_fifo_data = 32'hFFFF_FFFF.
  - On write: counter=0, go to SEND_LAUNCH.
- SEND_LAUNCH:
  - o_fifo_data = launch snapshot[counter].
  - On write with counter==LAUNCH_WORDS-1: go to IDLE, o_launch_done=1 next cycle.
- Latency and throughput:
  - Request accepted at cycle N; first write is possible at N+1.
  - With no back-pressure, a frame is FRAME_WORDS+1 consecutive writes and a launch is LAUNCH_WORDS+1.
  - The next request can be accepted in the cycle the done pulse is high, giving 1 idle cycle between messages.
- Framing invariants:
  - A header is never 0xFFFF_FFFF because exactly one header bit is 0.
  - Payload or launch words equal to 0xFFFF_FFFF are legal and sent unmodified.
- Ready is 0 in every state except IDLE. Inputs change freely after accept.
- Assertions (sim-only):
  - No write while i_fifo_full.
  - Header has exactly one zero in [31:31-DAC_CHANNEL+1].

Decomposition:
- Package dc_link_pkg:
  - LAUNCH_MARKER=32'hFFFF_FFFF.
  - HDR_TAG_W=8.
  - DAC_CHANNEL_MAX=24.
  - Packer state enum typedef.
  - Function encode_hdr(channel) returning the 32-bit header.
- Shared with the dispatcher for header validation.
- No sub-module; single module.

Test Plan:
- Frame, ch=5, regs[i]=32'hA000_0000+i, FIFO never full:
  - Expect 63 consecutive writes: first 32'hFFFFDF00, then A0000000..A000003D.
  - o_frame_done one cycle after the last write.
- Launch {11111111,22222222,33333333,44444444}:
  - Expect writes FFFFFFFF, 11111111, 22222222, 33333333, 44444444.
  - Then o_launch_done.
- Both valid in the same IDLE cycle:
  - Launch sequence fully first, frame ready=0 meanwhile.
  - Frame accepted in the cycle o_launch_done is high; its header is written in the following cycle.
- i_fifo_full asserted for 3 cycles at payload word 10:
  - No writes for those 3 cycles, o_fifo_data stable at regs[10], sequence resumes intact.
  - 63 total writes.
- i_channel_sel=24: o_err_chan pulse, zero writes, o_busy stays 0. Then ch=23 produces header 32'h7FFFFF00.
- i_rst_n low for 1 cycle at payload word 30:
  - Next cycle o_fifo_wr=0, o_busy=0, no o_frame_done.
  - A new frame sends its header first.
